// File: rtl/vram_arbiter.sv
// Single-port display RAM arbiter: video row fetches always win, CPU read/XOR
// row operations run atomically, and clear-screen yields to video between rows.
module vram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_row,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic [1:0]        cpu_op,
  input  logic [ADDR_W-1:0] cpu_row,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_collision,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [2:0] {IDLE, VID_RD, CPU_RD, CPU_WR, CLR} state_t;

  localparam logic [1:0]      LAT      = RD_LAT[1:0];
  localparam logic [1:0]      LAT_ONE  = 2'd1;
  localparam logic [ADDR_W:0] CLR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_reg, state_next;
  logic [1:0]          lat_cnt_reg, lat_cnt_next;
  logic                vid_pend_reg, vid_pend_next;
  logic [ADDR_W-1:0]   vid_row_pend_reg, vid_row_pend_next;
  logic                is_xor_reg, is_xor_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   old_reg, old_next;
  logic [ADDR_W:0]     clr_cnt_reg, clr_cnt_next;
  logic                clr_busy_reg, clr_busy_next;
  logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
  logic                ram_we_reg, ram_we_next;
  logic [DATA_W-1:0]   ram_wdata_reg, ram_wdata_next;
  logic                vid_valid_reg, vid_valid_next;
  logic [DATA_W-1:0]   vid_data_reg, vid_data_next;
  logic                cpu_done_reg, cpu_done_next;
  logic [DATA_W-1:0]   cpu_rdata_reg, cpu_rdata_next;
  logic                cpu_coll_reg, cpu_coll_next;

  // A fresh vid_req counts as pending in the same cycle so video is issued without delay.
  logic                vid_go;
  logic [ADDR_W-1:0]   vid_go_row;
  logic                issue_vid;

  assign vid_go     = vid_pend_reg | vid_req;
  assign vid_go_row = vid_req ? vid_row : vid_row_pend_reg;
  assign cpu_ready  = (state_reg == IDLE) && !vid_go && !rst;

  always_comb begin
    state_next        = state_reg;
    lat_cnt_next      = lat_cnt_reg;
    vid_pend_next     = vid_pend_reg;
    vid_row_pend_next = vid_row_pend_reg;
    is_xor_next       = is_xor_reg;
    wdata_next        = wdata_reg;
    old_next          = old_reg;
    clr_cnt_next      = clr_cnt_reg;
    clr_busy_next     = clr_busy_reg;
    ram_addr_next     = ram_addr_reg;
    ram_we_next       = 1'b0;
    ram_wdata_next    = ram_wdata_reg;
    vid_valid_next    = 1'b0;
    vid_data_next     = vid_data_reg;
    cpu_done_next     = 1'b0;
    cpu_rdata_next    = cpu_rdata_reg;
    cpu_coll_next     = cpu_coll_reg;
    issue_vid         = 1'b0;

    if (vid_req) begin
      vid_pend_next     = 1'b1;
      vid_row_pend_next = vid_row;
    end

    case (state_reg)
      IDLE: begin
        if (vid_go) begin
          issue_vid = 1'b1;
        end else if (cpu_req) begin
          is_xor_next = (cpu_op == 2'b01);
          wdata_next  = cpu_wdata;
          case (cpu_op)
            2'b00, 2'b01: begin
              ram_addr_next = cpu_row;
              lat_cnt_next  = 2'd0;
              state_next    = CPU_RD;
            end
            2'b10: begin
              clr_cnt_next  = '0;
              clr_busy_next = 1'b1;
              state_next    = CLR;
            end
            default: begin
              cpu_done_next = 1'b1;
              cpu_coll_next = 1'b0;
            end
          endcase
        end
      end
      VID_RD: begin
        if (lat_cnt_reg == LAT) begin
          vid_data_next  = ram_rdata;
          vid_valid_next = 1'b1;
          state_next     = clr_busy_reg ? CLR : IDLE;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_ONE;
        end
      end
      CPU_RD: begin
        if (lat_cnt_reg != LAT) begin
          lat_cnt_next = lat_cnt_reg + LAT_ONE;
        end else if (is_xor_reg) begin
          old_next       = ram_rdata;
          ram_wdata_next = ram_rdata ^ wdata_reg;
          ram_we_next    = 1'b1;
          state_next     = CPU_WR;
        end else begin
          cpu_rdata_next = ram_rdata;
          cpu_coll_next  = 1'b0;
          cpu_done_next  = 1'b1;
          state_next     = IDLE;
        end
      end
      CPU_WR: begin
        cpu_rdata_next = old_reg;
        cpu_coll_next  = |(old_reg & wdata_reg);
        cpu_done_next  = 1'b1;
        state_next     = IDLE;
      end
      CLR: begin
        // The counter's top bit marks that every row has already been written.
        if (clr_cnt_reg[ADDR_W]) begin
          clr_busy_next = 1'b0;
          cpu_coll_next = 1'b0;
          cpu_done_next = 1'b1;
          state_next    = IDLE;
        end else if (vid_go) begin
          issue_vid = 1'b1;
        end else begin
          ram_addr_next  = clr_cnt_reg[ADDR_W-1:0];
          ram_wdata_next = '0;
          ram_we_next    = 1'b1;
          clr_cnt_next   = clr_cnt_reg + CLR_ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (issue_vid) begin
      ram_addr_next = vid_go_row;
      lat_cnt_next  = 2'd0;
      vid_pend_next = 1'b0;
      state_next    = VID_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      lat_cnt_reg      <= '0;
      vid_pend_reg     <= 1'b0;
      vid_row_pend_reg <= '0;
      is_xor_reg       <= 1'b0;
      wdata_reg        <= '0;
      old_reg          <= '0;
      clr_cnt_reg      <= '0;
      clr_busy_reg     <= 1'b0;
      ram_addr_reg     <= '0;
      ram_we_reg       <= 1'b0;
      ram_wdata_reg    <= '0;
      vid_valid_reg    <= 1'b0;
      vid_data_reg     <= '0;
      cpu_done_reg     <= 1'b0;
      cpu_rdata_reg    <= '0;
      cpu_coll_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      lat_cnt_reg      <= lat_cnt_next;
      vid_pend_reg     <= vid_pend_next;
      vid_row_pend_reg <= vid_row_pend_next;
      is_xor_reg       <= is_xor_next;
      wdata_reg        <= wdata_next;
      old_reg          <= old_next;
      clr_cnt_reg      <= clr_cnt_next;
      clr_busy_reg     <= clr_busy_next;
      ram_addr_reg     <= ram_addr_next;
      ram_we_reg       <= ram_we_next;
      ram_wdata_reg    <= ram_wdata_next;
      vid_valid_reg    <= vid_valid_next;
      vid_data_reg     <= vid_data_next;
      cpu_done_reg     <= cpu_done_next;
      cpu_rdata_reg    <= cpu_rdata_next;
      cpu_coll_reg     <= cpu_coll_next;
    end
  end

  assign ram_addr      = ram_addr_reg;
  assign ram_we        = ram_we_reg;
  assign ram_wdata     = ram_wdata_reg;
  assign vid_valid     = vid_valid_reg;
  assign vid_data      = vid_data_reg;
  assign cpu_done      = cpu_done_reg;
  assign cpu_rdata     = cpu_rdata_reg;
  assign cpu_collision = cpu_coll_reg;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency RAM;
// inputs change and outputs are sampled on the falling clock edge.
module tb_vram_arbiter;
  localparam int AW = 5;
  localparam int DW = 64;

  localparam logic [DW-1:0] ROW5  = 64'hF000_0000_0000_0000;
  localparam logic [DW-1:0] ROW3  = 64'h00FF_00FF_00FF_00FF;
  localparam logic [DW-1:0] PAT_A = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [DW-1:0] ROW3X = 64'h0FF0_0FF0_0FF0_0FF0;
  localparam logic [DW-1:0] PAT_B = 64'hF00F_F00F_F00F_F00F;
  localparam logic [DW-1:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_row = '0;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          cpu_req = 1'b0;
  logic [1:0]    cpu_op = 2'b00;
  logic [AW-1:0] cpu_row = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_collision;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  logic [DW-1:0] mem [0:31];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_row(vid_row), .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_row(cpu_row), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_collision(cpu_collision),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Cycle n = n-th falling edge after the edge that accepts the op.
  task automatic cpu_run(input logic [1:0] op, input logic [AW-1:0] row, input logic [DW-1:0] wd,
                         output int lat, output int wes, output logic [DW-1:0] rd, output logic coll);
    lat = -1; wes = 0; rd = '0; coll = 1'b0;
    cpu_op = op; cpu_row = row; cpu_wdata = wd; cpu_req = 1'b1;
    for (int i = 0; i < 20 && !cpu_ready; i++) @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (ram_we) wes++;
      if (cpu_done) begin
        lat = n; rd = cpu_rdata; coll = cpu_collision;
        break;
      end
      @(negedge clk);
    end
    $display("cpu op=%0d row=%0d wdata=%h -> lat=%0d writes=%0d rdata=%h coll=%0b",
             op, row, wd, lat, wes, rd, coll);
  endtask

  task automatic vid_run(input logic [AW-1:0] row, output int lat, output logic [AW-1:0] addr1,
                         output logic [DW-1:0] data);
    lat = -1; addr1 = '0; data = '0;
    vid_req = 1'b1; vid_row = row;
    @(negedge clk);
    vid_req = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 1) addr1 = ram_addr;
      if (vid_valid) begin
        lat = n; data = vid_data;
        break;
      end
      @(negedge clk);
    end
    $display("vid row=%0d -> lat=%0d addr1=%0d data=%h", row, lat, addr1, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wes, nval, nreq, ndone, maxlat, last_req, badw, vid_at, done_at;
    logic [DW-1:0] rd, vd, orr;
    logic [AW-1:0] a1;
    logic coll, acc;

    // Preload RAM through the backdoor while reset is held.
    @(negedge clk);
    bd_we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bd_addr = AW'(i);
      bd_data = (i == 5) ? ROW5 : (i == 3) ? ROW3 : (64'hDEAD_BEEF_0000_0000 | 64'(i + 1));
      @(negedge clk);
    end
    bd_we = 1'b0;

    check("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    check("rst_vid_valid", 64'(vid_valid), 64'd0);
    check("rst_cpu_done", 64'(cpu_done), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(cpu_ready), 64'd1);

    // Video fetch: address in cycle 1, data in cycle 3.
    vid_run(5, lat, a1, vd);
    check("vid_addr_cycle1", 64'(a1), 64'd5);
    check("vid_latency", 64'(lat), 64'd3);
    check("vid_data", vd, ROW5);

    // XOR with overlap: write in cycle 3, done in cycle 4.
    cpu_run(2'b01, 3, PAT_A, lat, wes, rd, coll);
    check("xor1_latency", 64'(lat), 64'd4);
    check("xor1_writes", 64'(wes), 64'd1);
    check("xor1_rdata", rd, ROW3);
    check("xor1_coll", 64'(coll), 64'd1);
    check("xor1_row", mem[3], ROW3X);

    cpu_run(2'b01, 3, PAT_B, lat, wes, rd, coll);
    check("xor2_coll", 64'(coll), 64'd0);
    check("xor2_row", mem[3], ONES);
    cpu_run(2'b01, 3, PAT_B, lat, wes, rd, coll);
    check("xor3_coll", 64'(coll), 64'd1);
    check("xor3_rdata", rd, ONES);
    check("xor3_restored", mem[3], ROW3X);

    cpu_run(2'b00, 5, ONES, lat, wes, rd, coll);
    check("rd_latency", 64'(lat), 64'd3);
    check("rd_writes", 64'(wes), 64'd0);
    check("rd_rdata", rd, ROW5);
    check("rd_coll", 64'(coll), 64'd0);

    cpu_run(2'b11, 5, ONES, lat, wes, rd, coll);
    check("rsv_latency", 64'(lat), 64'd1);
    check("rsv_writes", 64'(wes), 64'd0);
    check("rsv_coll", 64'(coll), 64'd0);

    // Clear screen with a video request every 7 cycles.
    nval = 0; nreq = 0; ndone = 0; maxlat = 0; last_req = 0; badw = 0;
    cpu_op = 2'b10; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      if (vid_valid) begin
        nval++;
        if (cyc - last_req > maxlat) maxlat = cyc - last_req;
      end
      if (cpu_done) ndone++;
      if (ram_we && ram_wdata != '0) badw++;
      vid_req = (cyc % 7 == 3) && (cyc < 80);
      if (vid_req) begin
        vid_row = AW'(cyc);
        last_req = cyc;
        nreq++;
      end
      @(negedge clk);
    end
    vid_req = 1'b0;
    orr = '0;
    for (int i = 0; i < 32; i++) orr = orr | mem[i];
    $display("clear: done=%0d vid_req=%0d vid_valid=%0d max_lat=%0d or_rows=%h",
             ndone, nreq, nval, maxlat, orr);
    check("clr_done_once", 64'(ndone), 64'd1);
    check("clr_all_zero", orr, 64'd0);
    check("clr_nonzero_writes", 64'(badw), 64'd0);
    check("clr_vid_count", 64'(nval), 64'(nreq));
    check("clr_vid_within_6", 64'(maxlat <= 6), 64'd1);

    // Same-cycle video and CPU: video in cycle 3, CPU accepted then, done in cycle 7.
    vid_req = 1'b1; vid_row = 5;
    cpu_op = 2'b01; cpu_row = 2; cpu_wdata = 64'd1; cpu_req = 1'b1;
    #1;
    check("same_cycle_ready", 64'(cpu_ready), 64'd0);
    vid_at = -1; done_at = -1;
    @(negedge clk);
    vid_req = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (vid_valid && vid_at < 0) vid_at = n;
      if (cpu_done && done_at < 0) done_at = n;
      acc = cpu_req && cpu_ready;
      @(negedge clk);
      if (acc) cpu_req = 1'b0;
    end
    $display("same cycle: vid_valid at %0d, cpu_done at %0d", vid_at, done_at);
    check("same_vid_at", 64'(vid_at), 64'd3);
    check("same_done_at", 64'(done_at), 64'd7);
    check("same_row2", mem[2], 64'd1);

    // Reset during the cycle before CPU_WR aborts the write and the done pulse.
    cpu_op = 2'b01; cpu_row = 9; cpu_wdata = ONES; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready_in_rst", 64'(cpu_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wes = 0; ndone = 0;
    for (int n = 0; n < 6; n++) begin
      if (ram_we) wes++;
      if (cpu_done) ndone++;
      @(negedge clk);
      if (n == 0) check("abort_ready_after", 64'(cpu_ready), 64'd1);
    end
    $display("abort: writes=%0d done=%0d row9=%h", wes, ndone, mem[9]);
    check("abort_no_write", 64'(wes), 64'd0);
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_row9", mem[9], 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
